// File: rtl/gated_demod_accum.sv
// rtl/gated_demod_accum.sv - gated square-wave demodulator accumulating signed samples per modulation period
module gated_demod_accum #(
    parameter int HALF_LEN = 64,
    parameter int DEAD     = 4,
    parameter int DIN_W    = 16
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    en,
    input  logic                    trig,
    input  logic                    adc_valid,
    input  logic signed [DIN_W-1:0] adc_data,
    input  logic                    polarity,
    output logic signed [31:0]      dout,
    output logic                    dout_valid,
    output logic                    busy,
    output logic [7:0]              err_cnt
);

    localparam int CNT_W = (HALF_LEN > 2) ? $clog2(HALF_LEN) : 1;

    typedef enum logic [1:0] {IDLE, ARM, H1, H2} state_t;

    state_t                 state;
    logic signed [31:0]     acc;
    logic [CNT_W-1:0]       cnt;

    logic signed [31:0]     samp;
    logic                   take;
    logic                   last;
    logic signed [31:0]     sum_h2;
    logic signed [31:0]     result;
    logic signed [31:0]     acc_start;
    logic [CNT_W-1:0]       cnt_start;

    // Sample sign extension, dead-zone gating and the values a fresh H1 starts from
    always_comb begin
        samp      = {{(32-DIN_W){adc_data[DIN_W-1]}}, adc_data};
        take      = adc_valid && (int'(cnt) >= DEAD);
        last      = adc_valid && (cnt == CNT_W'(HALF_LEN - 1));
        sum_h2    = acc + samp;
        result    = polarity ? -sum_h2 : sum_h2;
        // The trigger cycle's sample is sample 0 of the new half, so it only counts when DEAD is 0
        acc_start = (adc_valid && (DEAD == 0)) ? -samp : 32'sd0;
        cnt_start = adc_valid ? CNT_W'(1) : CNT_W'(0);
    end

    // Period FSM with accumulator, counters and registered outputs
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            err_cnt    <= '0;
        end else begin
            dout_valid <= 1'b0;
            if (!en) begin
                state <= IDLE;
                acc   <= '0;
                cnt   <= '0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= ARM;
                        busy  <= 1'b0;
                    end
                    ARM: begin
                        if (trig) begin
                            state <= H1;
                            acc   <= acc_start;
                            cnt   <= cnt_start;
                            busy  <= 1'b1;
                        end
                    end
                    H1: begin
                        if (trig) begin
                            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                            acc <= acc_start;
                            cnt <= cnt_start;
                        end else if (adc_valid) begin
                            if (take) acc <= acc - samp;
                            if (last) begin
                                state <= H2;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end
                    H2: begin
                        if (last) begin
                            // A coincident trigger starts the next period without counting as an error
                            dout       <= result;
                            dout_valid <= 1'b1;
                            acc        <= '0;
                            cnt        <= '0;
                            if (trig) begin
                                state <= H1;
                                busy  <= 1'b1;
                            end else begin
                                state <= ARM;
                                busy  <= 1'b0;
                            end
                        end else if (trig) begin
                            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                            state <= H1;
                            acc   <= acc_start;
                            cnt   <= cnt_start;
                        end else if (adc_valid) begin
                            if (take) acc <= acc + samp;
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gated_demod_accum.sv
// tb/tb_gated_demod_accum.sv - scoreboard bench for gated_demod_accum
module tb_gated_demod_accum;

    logic               clk = 1'b0;
    logic               n_rst;

    logic               a_en, a_trig, a_valid, a_pol;
    logic signed [15:0] a_data;
    logic signed [31:0] a_dout;
    logic               a_dv, a_busy;
    logic [7:0]         a_err;

    logic               b_en, b_trig, b_valid, b_pol;
    logic signed [15:0] b_data;
    logic signed [31:0] b_dout;
    logic               b_dv, b_busy;
    logic [7:0]         b_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic signed [31:0] qa[$];
    logic signed [31:0] qb[$];

    always #5 clk = ~clk;

    gated_demod_accum #(.HALF_LEN(8), .DEAD(2), .DIN_W(16)) dut_a (
        .clk(clk), .n_rst(n_rst), .en(a_en), .trig(a_trig), .adc_valid(a_valid),
        .adc_data(a_data), .polarity(a_pol), .dout(a_dout), .dout_valid(a_dv),
        .busy(a_busy), .err_cnt(a_err)
    );

    gated_demod_accum #(.HALF_LEN(4096), .DEAD(0), .DIN_W(16)) dut_b (
        .clk(clk), .n_rst(n_rst), .en(b_en), .trig(b_trig), .adc_valid(b_valid),
        .adc_data(b_data), .polarity(b_pol), .dout(b_dout), .dout_valid(b_dv),
        .busy(b_busy), .err_cnt(b_err)
    );

    task automatic check(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic a_step(input logic t, input logic v, input logic signed [15:0] d);
        a_trig = t; a_valid = v; a_data = d;
        @(posedge clk); #1;
        a_trig = 1'b0; a_valid = 1'b0;
    endtask

    task automatic b_step(input logic t, input logic v, input logic signed [15:0] d);
        b_trig = t; b_valid = v; b_data = d;
        @(posedge clk); #1;
        b_trig = 1'b0; b_valid = 1'b0;
    endtask

    // Full clean period on dut_a: trig with first sample, h1_n samples of v1 then 8 of v2
    task automatic a_period(input logic signed [15:0] v1, input logic signed [15:0] v2);
        for (int i = 0; i < 16; i++) a_step(i == 0, 1'b1, (i < 8) ? v1 : v2);
    endtask

    // Monitor for dut_a results
    always @(negedge clk) begin
        if (n_rst && a_dv) begin
            if (qa.size() == 0) check("a_unexpected_valid", 32'sd1, 32'sd0);
            else check("a_dout", a_dout, qa.pop_front());
        end
    end

    // Monitor for dut_b results
    always @(negedge clk) begin
        if (n_rst && b_dv) begin
            if (qb.size() == 0) check("b_unexpected_valid", 32'sd1, 32'sd0);
            else check("b_dout", b_dout, qb.pop_front());
        end
    end

    initial begin
        n_rst = 1'b0;
        a_en = 0; a_trig = 0; a_valid = 0; a_pol = 0; a_data = 0;
        b_en = 0; b_trig = 0; b_valid = 0; b_pol = 0; b_data = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", a_dout, 32'sd0);
        check("rst_busy", 32'(a_busy), 32'sd0);
        check("rst_err", 32'(a_err), 32'sd0);
        check("rst_valid", 32'(a_dv), 32'sd0);
        n_rst = 1'b1;
        a_en = 1'b1; b_en = 1'b1;
        a_step(0, 0, 0); a_step(0, 0, 0);

        // Full-scale period without wrap on the long instance
        qb.push_back(32'sd268431360);
        for (int i = 0; i < 8192; i++) b_step(i == 0, 1'b1, (i < 4096) ? -16'sd32768 : 16'sd32767);
        b_step(0, 0, 0); b_step(0, 0, 0);
        check("b_err", 32'(b_err), 32'sd0);

        // Basic period
        qa.push_back(32'sd1200);
        a_step(1, 1, 100);
        check("busy_h1", 32'(a_busy), 32'sd1);
        for (int i = 1; i < 16; i++) a_step(0, 1'b1, (i < 8) ? 16'sd100 : 16'sd300);
        a_step(0, 0, 0);
        check("t1_err", 32'(a_err), 32'sd0);
        check("t1_busy_done", 32'(a_busy), 32'sd0);

        // Negated with gapped adc_valid
        a_pol = 1'b1;
        qa.push_back(-32'sd1200);
        for (int i = 0; i < 16; i++) begin
            a_step(i == 0, 1'b1, (i < 8) ? 16'sd100 : 16'sd300);
            a_step(0, 1'b0, 16'sd7);
        end
        a_pol = 1'b0;
        check("t2_err", 32'(a_err), 32'sd0);
        check("t2_dout_hold", a_dout, -32'sd1200);

        // Early trigger aborts, then a clean period
        for (int i = 0; i < 5; i++) a_step(i == 0, 1'b1, 16'sd10);
        qa.push_back(32'sd60);
        a_period(16'sd10, 16'sd20);
        a_step(0, 0, 0);
        check("t4_err", 32'(a_err), 32'sd1);

        // Trigger coincident with completion, second period follows without a trigger
        qa.push_back(32'sd1200);
        qa.push_back(32'sd600);
        for (int i = 0; i < 16; i++) a_step((i == 0) || (i == 15), 1'b1, (i < 8) ? 16'sd100 : 16'sd300);
        check("t5_busy_rearm", 32'(a_busy), 32'sd1);
        for (int i = 0; i < 16; i++) a_step(0, 1'b1, (i < 8) ? 16'sd50 : 16'sd150);
        a_step(0, 0, 0);
        check("t5_err", 32'(a_err), 32'sd1);

        // Early-trigger saturation
        for (int i = 0; i < 301; i++) a_step(1, 0, 0);
        check("sat_err", 32'(a_err), 32'sd255);

        // en drop mid-H1
        a_step(0, 1, 5); a_step(0, 1, 5);
        a_en = 1'b0;
        a_step(0, 1, 5);
        check("en_busy", 32'(a_busy), 32'sd0);
        check("en_dout_hold", a_dout, 32'sd600);
        check("en_err_hold", 32'(a_err), 32'sd255);
        a_en = 1'b1;
        a_step(0, 0, 0); a_step(0, 0, 0);

        // Async reset mid-H2 with a held result
        qa.push_back(32'sd1200);
        a_period(16'sd100, 16'sd300);
        a_step(0, 0, 0);
        for (int i = 0; i < 11; i++) a_step(i == 0, 1'b1, 16'sd100);
        check("pre_rst_dout", a_dout, 32'sd1200);
        #2;
        n_rst = 1'b0;
        #1;
        check("arst_dout", a_dout, 32'sd0);
        check("arst_busy", 32'(a_busy), 32'sd0);
        check("arst_err", 32'(a_err), 32'sd0);
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        repeat (20) a_step(0, 1, 100);
        check("post_rst_dout", a_dout, 32'sd0);

        check("a_pending", 32'(qa.size()), 32'sd0);
        check("b_pending", 32'(qb.size()), 32'sd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
